connect_k_game: RTL and testbench

CONNECT_K_GAME -- requirements
Module: connect_k_game

---
 rtl/connect_k_game_if.sv | 41 ++++
 rtl/connect_k_game.sv | 165 ++++++++++++++++
 tb/tb_connect_k_game.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/connect_k_game_if.sv
// connect_k_game_if -- player-facing bus of the connect-K game.
//   master: drives square select and the two commit buttons, observes board/status.
//   slave : the game engine.
//   sel_pos       N*N  one-hot square select
//   buttonX/O     1    commit requests
//   turnX/O       1    side to move
//   occ_square    N*N  occupied squares
//   occ_player    N*N  owner (1 = X, 0 = O)
//   occ_pos       N*N  display board (flashes winning line)
//   win_mask      N*N  union of winning K-lines
//   move_count    5    accepted moves
//   game_st_ascii 8    status character
interface connect_k_game_if #(
   parameter int N = 3
);
   localparam int SQ = N * N;

   logic [SQ-1:0] sel_pos;
   logic          buttonX;
   logic          buttonO;
   logic          turnX;
   logic          turnO;
   logic [SQ-1:0] occ_square;
   logic [SQ-1:0] occ_player;
   logic [SQ-1:0] occ_pos;
   logic [SQ-1:0] win_mask;
   logic [4:0]    move_count;
   logic [7:0]    game_st_ascii;

   modport master (
      output sel_pos, buttonX, buttonO,
      input  turnX, turnO, occ_square, occ_player, occ_pos, win_mask,
             move_count, game_st_ascii
   );

   modport slave (
      input  sel_pos, buttonX, buttonO,
      output turnX, turnO, occ_square, occ_player, occ_pos, win_mask,
             move_count, game_st_ascii
   );
endinterface

// File: rtl/connect_k_game.sv
// connect_k_game -- two-player connect-K on an N x N board (square = row*N + col).
// Moore FSM: a player presses its button, the select is validated one cycle
// later, the registered board is then scanned for a K-line, and play passes
// to the other side. Win/draw states are terminal until reset.
// Ports:
//   clk   sole clock, rising edge
//   reset synchronous, active high
//   bus   connect_k_game_if.slave (select/buttons in, board/status out)
module connect_k_game #(
   parameter int N         = 3,
   parameter int K         = 3,
   parameter int FLASH_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   connect_k_game_if.slave  bus
);
   localparam int SQ = N * N;
   localparam int NL = 4 * SQ;                 // 4 directions anchored at every square
   localparam int CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

   typedef enum logic [3:0] {
      START, TURN_X, CHKV_X, CHKW_X, ERR_X, WIN_X,
      TURN_O, CHKV_O, CHKW_O, ERR_O, WIN_O, CATS
   } state_t;

   state_t          st, nxt;
   logic [SQ-1:0]   occ_sq, occ_pl, wmask;
   logic [4:0]      mcnt;
   logic [CW-1:0]   fcnt;
   logic            flash_ph;
   logic            turn_x, turn_o;
   logic [7:0]      ascii;

   logic [SQ-1:0]   sel;
   logic            sel_ok, mv_ok, in_win;
   logic [SQ-1:0]   own_x, own_o, uni_x, uni_o;
   logic [NL-1:0][SQ-1:0] hit_x, hit_o;

   assign sel    = bus.sel_pos;
   // exactly one bit set and that square still free
   assign sel_ok = (sel != '0) && ((sel & (sel - 1'b1)) == '0) && ((sel & occ_sq) == '0);
   assign mv_ok  = ((st == CHKV_X) || (st == CHKV_O)) && sel_ok;
   assign in_win = (st == WIN_X) || (st == WIN_O);

   assign own_x = occ_sq & occ_pl;
   assign own_o = occ_sq & ~occ_pl;

   // Mask of the K squares starting at (r,c) stepping (dr,dc).
   function automatic logic [SQ-1:0] line_mask(int r, int c, int dr, int dc);
      logic [SQ-1:0] m;
      m = '0;
      for (int i = 0; i < K; i++) m[(r + i*dr)*N + c + i*dc] = 1'b1;
      return m;
   endfunction

   // Every K-window that fits on the board, in every direction. A window
   // anchored at (r,c) is kept only if its far end stays in bounds, so
   // non-edge windows are covered when K < N.
   for (genvar r = 0; r < N; r++) begin : g_r
      for (genvar c = 0; c < N; c++) begin : g_c
         for (genvar d = 0; d < 4; d++) begin : g_d
            // d: 0 column, 1 row, 2 diagonal, 3 anti-diagonal
            localparam int DR = (d == 1) ? 0 : 1;
            localparam int DC = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
            localparam int ER = r + (K-1)*DR;
            localparam int EC = c + (K-1)*DC;
            localparam int IX = (r*N + c)*4 + d;
            if (ER < N && EC >= 0 && EC < N) begin : g_ok
               localparam logic [SQ-1:0] M = line_mask(r, c, DR, DC);
               assign hit_x[IX] = ((own_x & M) == M) ? M : '0;
               assign hit_o[IX] = ((own_o & M) == M) ? M : '0;
            end else begin : g_no
               assign hit_x[IX] = '0;
               assign hit_o[IX] = '0;
            end
         end
      end
   end

   always_comb begin
      uni_x = '0;
      uni_o = '0;
      for (int i = 0; i < NL; i++) begin
         uni_x = uni_x | hit_x[i];
         uni_o = uni_o | hit_o[i];
      end
   end

   always_comb begin
      nxt = st;
      case (st)
         START:  nxt = TURN_X;
         TURN_X: if (bus.buttonO) nxt = ERR_X; else if (bus.buttonX) nxt = CHKV_X;
         ERR_X:  if (bus.buttonX) nxt = CHKV_X;
         CHKV_X: nxt = sel_ok ? CHKW_X : ERR_X;
         CHKW_X: nxt = (uni_x != '0) ? WIN_X : ((mcnt == 5'(SQ)) ? CATS : TURN_O);
         TURN_O: if (bus.buttonX) nxt = ERR_O; else if (bus.buttonO) nxt = CHKV_O;
         ERR_O:  if (bus.buttonO) nxt = CHKV_O;
         CHKV_O: nxt = sel_ok ? CHKW_O : ERR_O;
         CHKW_O: nxt = (uni_o != '0) ? WIN_O : ((mcnt == 5'(SQ)) ? CATS : TURN_X);
         default: nxt = st;                    // WIN_X, WIN_O, CATS hold
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= START;
         occ_sq   <= '0;
         occ_pl   <= '0;
         mcnt     <= '0;
         wmask    <= '0;
         fcnt     <= '0;
         flash_ph <= 1'b1;
         turn_x   <= 1'b0;
         turn_o   <= 1'b0;
         ascii    <= 8'h6E;
      end else begin
         st     <= nxt;
         // status outputs are registered from the next state so they
         // line up with st
         turn_x <= (nxt == TURN_X) || (nxt == ERR_X);
         turn_o <= (nxt == TURN_O) || (nxt == ERR_O);
         case (nxt)
            ERR_X, ERR_O: ascii <= 8'h45;
            WIN_X:        ascii <= 8'h58;
            WIN_O:        ascii <= 8'h4F;
            CATS:         ascii <= 8'h43;
            default:      ascii <= 8'h6E;
         endcase

         if (mv_ok) begin
            occ_sq <= occ_sq | sel;
            occ_pl <= (st == CHKV_X) ? (occ_pl | sel) : (occ_pl & ~sel);
            mcnt   <= mcnt + 5'd1;
         end

         // latched once on entry; WIN states are terminal so it holds
         if (st == CHKW_X && nxt == WIN_X)      wmask <= uni_x;
         else if (st == CHKW_O && nxt == WIN_O) wmask <= uni_o;

         // counter/phase idle at 0/1 outside WIN so entry starts lit
         if (in_win) begin
            if (fcnt == CW'(FLASH_DIV - 1)) begin
               fcnt     <= '0;
               flash_ph <= ~flash_ph;
            end else begin
               fcnt <= fcnt + CW'(1);
            end
         end else begin
            fcnt     <= '0;
            flash_ph <= 1'b1;
         end
      end
   end

   assign bus.turnX         = turn_x;
   assign bus.turnO         = turn_o;
   assign bus.game_st_ascii = ascii;
   assign bus.occ_square    = occ_sq;
   assign bus.occ_player    = occ_pl;
   assign bus.move_count    = mcnt;
   assign bus.win_mask      = wmask;
   assign bus.occ_pos       = in_win ? ((wmask & {SQ{flash_ph}}) | (occ_sq & ~wmask)) : occ_sq;
endmodule

// File: tb/tb_connect_k_game.sv
// Bench for connect_k_game: a 3x3/K=3 instance driven from a move table with a
// scoreboard queue, plus a 5x5/K=4 instance for the off-edge diagonal win.
module tb_connect_k_game;
   logic clk = 1'b0;
   logic rst3, rst5;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   connect_k_game_if #(.N(3)) b3 ();
   connect_k_game_if #(.N(5)) b5 ();

   connect_k_game #(.N(3), .K(3), .FLASH_DIV(4)) dut3 (.clk(clk), .reset(rst3), .bus(b3));
   connect_k_game #(.N(5), .K(4), .FLASH_DIV(4)) dut5 (.clk(clk), .reset(rst5), .bus(b5));

   typedef struct {
      logic       rst;        // reset the game before this move
      logic       bx, bo;
      logic [8:0] sel;
      logic [7:0] asc;
      logic       tx, to;
      logic [4:0] mc;
      logic [8:0] osq, opl, wm;
   } vec_t;

   vec_t tbl[19];
   vec_t exp_q[$];

   function automatic vec_t mk(logic r, logic bx, logic bo, logic [8:0] sel, logic [7:0] asc,
                               logic tx, logic to, logic [4:0] mc, logic [8:0] osq,
                               logic [8:0] opl, logic [8:0] wm);
      vec_t v;
      v.rst = r; v.bx = bx; v.bo = bo; v.sel = sel; v.asc = asc; v.tx = tx; v.to = to;
      v.mc = mc; v.osq = osq; v.opl = opl; v.wm = wm;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset3();
      rst3 = 1'b1; b3.buttonX = 1'b1; b3.buttonO = 1'b1;
      step();
      chk("rst3_occ_square", 32'(b3.occ_square), 0);
      chk("rst3_occ_player", 32'(b3.occ_player), 0);
      chk("rst3_occ_pos",    32'(b3.occ_pos), 0);
      chk("rst3_win_mask",   32'(b3.win_mask), 0);
      chk("rst3_move_count", 32'(b3.move_count), 0);
      chk("rst3_turns",      32'({b3.turnX, b3.turnO}), 0);
      chk("rst3_ascii",      32'(b3.game_st_ascii), 32'h6E);
      rst3 = 1'b0; b3.buttonX = 1'b0; b3.buttonO = 1'b0;
      step();
      chk("start_to_turnx", 32'({b3.turnX, b3.turnO}), 32'b10);
   endtask

   task automatic do_reset5();
      rst5 = 1'b1; b5.buttonX = 1'b1;
      step();
      chk("rst5_board", 32'(b5.occ_square | b5.occ_player | b5.occ_pos | b5.win_mask), 0);
      chk("rst5_move_count", 32'(b5.move_count), 0);
      chk("rst5_turns", 32'({b5.turnX, b5.turnO}), 0);
      chk("rst5_ascii", 32'(b5.game_st_ascii), 32'h6E);
      rst5 = 1'b0; b5.buttonX = 1'b0;
      step();
   endtask

   // press button for one cycle, then let CHKV and CHKW run
   task automatic apply3(input vec_t v);
      vec_t e;
      if (v.rst) do_reset3();
      exp_q.push_back(v);
      b3.sel_pos = v.sel; b3.buttonX = v.bx; b3.buttonO = v.bo;
      step();
      b3.buttonX = 1'b0; b3.buttonO = 1'b0;
      step();
      step();
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk("ascii",      32'(b3.game_st_ascii), 32'(e.asc));
         chk("turns",      32'({b3.turnX, b3.turnO}), 32'({e.tx, e.to}));
         chk("move_count", 32'(b3.move_count), 32'(e.mc));
         chk("occ_square", 32'(b3.occ_square), 32'(e.osq));
         chk("occ_player", 32'(b3.occ_player & b3.occ_square), 32'(e.opl));
         chk("occ_pos",    32'(b3.occ_pos), 32'(e.osq));
         chk("win_mask",   32'(b3.win_mask), 32'(e.wm));
      end
   endtask

   task automatic mv5(input logic bx, input logic bo, input logic [24:0] sel);
      b5.sel_pos = sel; b5.buttonX = bx; b5.buttonO = bo;
      step();
      b5.buttonX = 1'b0; b5.buttonO = 1'b0;
      step();
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [8:0] fexp;
      rst3 = 1'b1; rst5 = 1'b1;
      b3.sel_pos = '0; b3.buttonX = 1'b0; b3.buttonO = 1'b0;
      b5.sel_pos = '0; b5.buttonX = 1'b0; b5.buttonO = 1'b0;

      // draw: X4 O0 X2 O6 X3 O5 X1 O7 X8
      tbl[0]  = mk(1, 1, 0, 9'h010, 8'h6E, 0, 1, 1, 9'h010, 9'h010, 0);
      tbl[1]  = mk(0, 0, 1, 9'h001, 8'h6E, 1, 0, 2, 9'h011, 9'h010, 0);
      tbl[2]  = mk(0, 1, 0, 9'h004, 8'h6E, 0, 1, 3, 9'h015, 9'h014, 0);
      tbl[3]  = mk(0, 0, 1, 9'h040, 8'h6E, 1, 0, 4, 9'h055, 9'h014, 0);
      tbl[4]  = mk(0, 1, 0, 9'h008, 8'h6E, 0, 1, 5, 9'h05D, 9'h01C, 0);
      tbl[5]  = mk(0, 0, 1, 9'h020, 8'h6E, 1, 0, 6, 9'h07D, 9'h01C, 0);
      tbl[6]  = mk(0, 1, 0, 9'h002, 8'h6E, 0, 1, 7, 9'h07F, 9'h01E, 0);
      tbl[7]  = mk(0, 0, 1, 9'h080, 8'h6E, 1, 0, 8, 9'h0FF, 9'h01E, 0);
      tbl[8]  = mk(0, 1, 0, 9'h100, 8'h43, 0, 0, 9, 9'h1FF, 9'h11E, 0);
      // O on an occupied square, then a legal O move (reset mid-game follows)
      tbl[9]  = mk(1, 1, 0, 9'h010, 8'h6E, 0, 1, 1, 9'h010, 9'h010, 0);
      tbl[10] = mk(0, 0, 1, 9'h010, 8'h45, 0, 1, 1, 9'h010, 9'h010, 0);
      tbl[11] = mk(0, 0, 1, 9'h001, 8'h6E, 1, 0, 2, 9'h011, 9'h010, 0);
      // empty select, two-hot select, wrong button, then X diagonal win
      tbl[12] = mk(1, 1, 0, 9'h000, 8'h45, 1, 0, 0, 9'h000, 9'h000, 0);
      tbl[13] = mk(0, 1, 0, 9'h003, 8'h45, 1, 0, 0, 9'h000, 9'h000, 0);
      tbl[14] = mk(0, 1, 0, 9'h001, 8'h6E, 0, 1, 1, 9'h001, 9'h001, 0);
      tbl[15] = mk(0, 0, 1, 9'h002, 8'h6E, 1, 0, 2, 9'h003, 9'h001, 0);
      tbl[16] = mk(0, 0, 1, 9'h010, 8'h45, 1, 0, 2, 9'h003, 9'h001, 0);
      tbl[17] = mk(0, 1, 0, 9'h010, 8'h6E, 0, 1, 3, 9'h013, 9'h011, 0);
      tbl[18] = mk(0, 0, 1, 9'h004, 8'h6E, 1, 0, 4, 9'h017, 9'h011, 0);

      for (int i = 0; i < 19; i++) apply3(tbl[i]);
      apply3(mk(0, 1, 0, 9'h100, 8'h58, 0, 0, 5, 9'h117, 9'h111, 9'h111));

      // first WIN_X cycle: winning squares flash 4 on / 4 off, others steady
      for (int i = 0; i < 16; i++) begin
         fexp = (((i / 4) % 2) == 0) ? 9'h117 : 9'h006;
         chk("flash_occ_pos", 32'(b3.occ_pos), 32'(fexp));
         b3.sel_pos = 9'h008; b3.buttonX = (i == 5); b3.buttonO = (i == 9);
         step();
      end
      b3.buttonX = 1'b0; b3.buttonO = 1'b0;
      chk("win_hold_ascii", 32'(b3.game_st_ascii), 32'h58);
      chk("win_hold_board", 32'(b3.occ_square), 32'h117);
      chk("win_hold_count", 32'(b3.move_count), 5);
      do_reset3();

      // 5x5, K=4: diagonal 0,6,12,18 not reaching the far corner
      do_reset5();
      mv5(1, 0, 25'h0000001);
      mv5(0, 1, 25'h0000002);
      mv5(1, 0, 25'h0000040);
      mv5(0, 1, 25'h0000004);
      mv5(1, 0, 25'h0001000);
      mv5(0, 1, 25'h0000008);
      chk("n5_pre_ascii", 32'(b5.game_st_ascii), 32'h6E);
      chk("n5_pre_win_mask", 32'(b5.win_mask), 0);
      mv5(1, 0, 25'h0040000);
      chk("n5_ascii", 32'(b5.game_st_ascii), 32'h58);
      chk("n5_win_mask", 32'(b5.win_mask), 32'h41041);
      chk("n5_move_count", 32'(b5.move_count), 7);
      do_reset5();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
